ex_mem_stage: RTL and testbench

Pipeline register between the execute stage (ALU) and the memory stage of the CPU. It captures the ALU result, zero flag and the control/payload bits that travel with the instruction, and resolves branch-taken. A 2-entry skid buffer with valid/ready handshakes on both sides lets the memory stage stall without a combinational ready path back into execute.

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/ex_mem_stage_if.sv | 55 +++++
 rtl/pipe_skid_buffer.sv | 104 ++++++++++
 rtl/ex_mem_stage.sv | 82 ++++++++
 tb/tb_ex_mem_stage.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU definitions used by the EX/MEM pipeline register.
// It holds:
//   - the datapath widths MAX_SIZE and REG_ADDR_W;
//   - the ALU op codes;
//   - the EX/MEM payload bit layout (field offsets and total width);
//   - the state encoding of the 2-entry skid buffer.
package cpu_pkg;

  localparam int MAX_SIZE   = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_e;

  // EX/MEM payload layout, LSB first:
  //   result | store_data | rd | reg_write | mem_read | mem_write | branch_taken
  function automatic int exm_store_lsb(input int ms);
    return ms;
  endfunction

  function automatic int exm_rd_lsb(input int ms);
    return 2 * ms;
  endfunction

  function automatic int exm_ctrl_lsb(input int ms, input int ra);
    return 2 * ms + ra;
  endfunction

  function automatic int exm_payload_w(input int ms, input int ra);
    return 2 * ms + ra + 4;
  endfunction

  localparam int EXM_RESULT_LSB   = 0;
  localparam int EXM_STORE_LSB    = exm_store_lsb(MAX_SIZE);
  localparam int EXM_RD_LSB       = exm_rd_lsb(MAX_SIZE);
  localparam int EXM_REG_WRITE    = exm_ctrl_lsb(MAX_SIZE, REG_ADDR_W);
  localparam int EXM_MEM_READ     = EXM_REG_WRITE + 1;
  localparam int EXM_MEM_WRITE    = EXM_REG_WRITE + 2;
  localparam int EXM_BRANCH_TAKEN = EXM_REG_WRITE + 3;
  localparam int EXM_PAYLOAD_W    = exm_payload_w(MAX_SIZE, REG_ADDR_W);

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: handshake and payload bundle between the execute stage,
// the EX/MEM register and the memory stage.
//   slave  : the EX/MEM register's view
//            - inputs:  in_*, flush, out_ready
//            - outputs: in_ready, out_*
//   master : the surrounding pipeline's view (signal directions mirrored)
interface ex_mem_stage_if #(
  parameter int MAX_SIZE   = cpu_pkg::MAX_SIZE,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
);

  logic                  flush;

  logic                  in_valid;
  logic                  in_ready;
  logic [MAX_SIZE-1:0]   in_result;
  logic                  in_zero;
  logic [MAX_SIZE-1:0]   in_store_data;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_reg_write;
  logic                  in_mem_read;
  logic                  in_mem_write;
  logic                  in_branch;

  logic                  out_valid;
  logic                  out_ready;
  logic [MAX_SIZE-1:0]   out_result;
  logic [MAX_SIZE-1:0]   out_store_data;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_reg_write;
  logic                  out_mem_read;
  logic                  out_mem_write;
  logic                  out_branch_taken;

  modport slave (
    input  flush,
    input  in_valid, in_result, in_zero, in_store_data, in_rd,
           in_reg_write, in_mem_read, in_mem_write, in_branch,
    output in_ready,
    output out_valid, out_result, out_store_data, out_rd,
           out_reg_write, out_mem_read, out_mem_write, out_branch_taken,
    input  out_ready
  );

  modport master (
    output flush,
    output in_valid, in_result, in_zero, in_store_data, in_rd,
           in_reg_write, in_mem_read, in_mem_write, in_branch,
    input  in_ready,
    input  out_valid, out_result, out_store_data, out_rd,
           out_reg_write, out_mem_read, out_mem_write, out_branch_taken,
    output out_ready
  );

endinterface

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: 2-entry valid/ready register stage on a flat payload.
//
// Entries:
//   - main drives out_data;
//   - skid catches one extra entry when the consumer stalls.
//
// Handshake:
//   - in_ready is a flop, so there is no combinational path from out_ready
//     back to the producer.
//   - flush squashes both entries at the next edge; any accept or consume
//     in that same cycle is discarded.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous squash of all held entries
//   in_valid/in_ready   producer handshake, in_data payload
//   out_valid/out_ready consumer handshake, out_data payload
module pipe_skid_buffer
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic accept;
  logic consume;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = main_q;

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Payload is left as-is; validity alone squashes the entries.
      state_d = SKID_EMPTY;
    end else begin
      unique case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept && !consume) begin
            skid_d  = in_data;
            state_d = SKID_TWO;
          end else if (consume && !accept) begin
            state_d = SKID_EMPTY;
          end else if (accept && consume) begin
            main_d  = in_data;
          end
        end
        SKID_TWO: begin
          // in_ready_q is low here, so accept cannot fire.
          if (consume) begin
            main_d  = skid_q;
            state_d = SKID_ONE;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end

    // Precomputed from the next state so in_ready leaves a flop.
    in_ready_d = (state_d != SKID_TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SKID_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register of the CPU.
//
// Function:
//   - Captures the ALU result, store data, destination register and the
//     memory/writeback control bits.
//   - Resolves branch-taken (in_branch & in_zero) at capture time and
//     stores it with the entry.
//   - Holds entries in a 2-entry skid buffer so the memory stage can stall
//     without a combinational ready path back into execute.
//   - Qualifies the control outputs with out_valid, so a squashed or empty
//     stage never issues a write.
//
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  ex_mem_stage_if.slave, which carries:
//          - flush
//          - the in_* handshake and payload
//          - the out_* handshake and payload
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int MAX_SIZE   = cpu_pkg::MAX_SIZE,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  ex_mem_stage_if.slave        bus
);

  localparam int PW        = exm_payload_w(MAX_SIZE, REG_ADDR_W);
  localparam int STORE_LSB = exm_store_lsb(MAX_SIZE);
  localparam int RD_LSB    = exm_rd_lsb(MAX_SIZE);
  localparam int CTRL_LSB  = exm_ctrl_lsb(MAX_SIZE, REG_ADDR_W);

  logic [PW-1:0] in_payload;
  logic [PW-1:0] out_payload;
  logic          out_valid;
  logic          in_ready;
  logic          branch_taken;

  // The only payload logic: the branch decision is made here once.
  assign branch_taken = bus.in_branch & bus.in_zero;

  assign in_payload = {branch_taken,
                       bus.in_mem_write,
                       bus.in_mem_read,
                       bus.in_reg_write,
                       bus.in_rd,
                       bus.in_store_data,
                       bus.in_result};

  pipe_skid_buffer #(
    .WIDTH (PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_payload)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;

  // Data fields pass straight through.
  assign bus.out_result     = out_payload[MAX_SIZE-1:0];
  assign bus.out_store_data = out_payload[STORE_LSB +: MAX_SIZE];
  assign bus.out_rd         = out_payload[RD_LSB +: REG_ADDR_W];

  // Control bits are gated by out_valid: after a flush, the payload
  // registers may still hold a squashed instruction.
  assign bus.out_reg_write    = out_valid & out_payload[CTRL_LSB];
  assign bus.out_mem_read     = out_valid & out_payload[CTRL_LSB + 1];
  assign bus.out_mem_write    = out_valid & out_payload[CTRL_LSB + 2];
  assign bus.out_branch_taken = out_valid & out_payload[CTRL_LSB + 3];

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  logic clk;
  logic rst;

  ex_mem_stage_if #(.MAX_SIZE(32), .REG_ADDR_W(5)) bus ();

  ex_mem_stage #(.MAX_SIZE(32), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        bt;
  } ent_t;

  // Reference model: the stage is an in-order FIFO of capacity two.
  ent_t q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input bit v, input logic [31:0] res, input bit z, input bit br);
    bus.in_valid      = v;
    bus.in_result     = res;
    bus.in_zero       = z;
    bus.in_branch     = br;
    bus.in_store_data = $urandom;
    bus.in_rd         = 5'($urandom_range(0, 31));
    bus.in_reg_write  = 1'($urandom_range(0, 1));
    bus.in_mem_read   = 1'($urandom_range(0, 1));
    bus.in_mem_write  = 1'($urandom_range(0, 1));
  endtask

  task automatic model_edge();
    bit   acc;
    bit   con;
    ent_t e;
    if (bus.flush) begin
      q.delete();
    end else begin
      acc = bus.in_valid && (q.size() < 2);
      con = (q.size() > 0) && bus.out_ready;
      if (con) void'(q.pop_front());
      if (acc) begin
        e.res = bus.in_result;
        e.sd  = bus.in_store_data;
        e.rd  = bus.in_rd;
        e.rw  = bus.in_reg_write;
        e.mr  = bus.in_mem_read;
        e.mw  = bus.in_mem_write;
        e.bt  = bus.in_branch && bus.in_zero;
        q.push_back(e);
      end
    end
  endtask

  task automatic check_state();
    chk("out_valid", bus.out_valid, q.size() > 0);
    chk("in_ready", bus.in_ready, q.size() < 2);
    if (q.size() > 0) begin
      chk("out_result", bus.out_result, q[0].res);
      chk("out_store_data", bus.out_store_data, q[0].sd);
      chk("out_rd", bus.out_rd, q[0].rd);
      chk("out_reg_write", bus.out_reg_write, q[0].rw);
      chk("out_mem_read", bus.out_mem_read, q[0].mr);
      chk("out_mem_write", bus.out_mem_write, q[0].mw);
      chk("out_branch_taken", bus.out_branch_taken, q[0].bt);
    end else begin
      chk("idle_reg_write", bus.out_reg_write, 0);
      chk("idle_mem_read", bus.out_mem_read, 0);
      chk("idle_mem_write", bus.out_mem_write, 0);
      chk("idle_branch_taken", bus.out_branch_taken, 0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_state();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_result"}, bus.out_result, 0);
    chk({tag, "_out_store_data"}, bus.out_store_data, 0);
    chk({tag, "_out_rd"}, bus.out_rd, 0);
    chk({tag, "_out_reg_write"}, bus.out_reg_write, 0);
    chk({tag, "_out_mem_read"}, bus.out_mem_read, 0);
    chk({tag, "_out_mem_write"}, bus.out_mem_write, 0);
    chk({tag, "_out_branch_taken"}, bus.out_branch_taken, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    put(1'b0, 32'h0, 1'b0, 1'b0);

    // Power-on reset
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Streaming: four back-to-back entries, consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      put(1'b1, 32'(i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cycle();
      chk("stream_result", bus.out_result, 32'(i));
      chk("stream_in_ready", bus.in_ready, 1);
    end
    put(1'b0, 32'h0, 1'b0, 1'b0);
    cycle();

    // Stall/skid: A then B while stalled, then drain
    bus.out_ready = 1'b0;
    put(1'b1, 32'hA, 1'b0, 1'b0);
    cycle();
    put(1'b1, 32'hB, 1'b0, 1'b0);
    cycle();
    chk("skid_in_ready_low", bus.in_ready, 0);
    chk("skid_hold_A", bus.out_result, 32'hA);
    put(1'b1, 32'hDEAD, 1'b0, 1'b0);  // offered while full, must be ignored
    cycle();
    chk("skid_still_A", bus.out_result, 32'hA);
    put(1'b0, 32'h0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    cycle();
    chk("skid_drain_B", bus.out_result, 32'hB);
    cycle();
    chk("skid_empty", bus.out_valid, 0);

    // Branch resolution
    put(1'b1, 32'h10, 1'b1, 1'b1);
    cycle();
    chk("branch_z1_b1", bus.out_branch_taken, 1);
    put(1'b1, 32'h11, 1'b0, 1'b1);
    cycle();
    chk("branch_z0_b1", bus.out_branch_taken, 0);
    put(1'b1, 32'h12, 1'b1, 1'b0);
    cycle();
    chk("branch_z1_b0", bus.out_branch_taken, 0);
    put(1'b0, 32'h0, 1'b0, 1'b0);
    cycle();

    // Flush with two entries held and a third offered
    bus.out_ready = 1'b0;
    put(1'b1, 32'h21, 1'b0, 1'b0);
    cycle();
    put(1'b1, 32'h22, 1'b0, 1'b0);
    cycle();
    put(1'b1, 32'h23, 1'b1, 1'b1);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    bus.flush = 1'b0;
    put(1'b0, 32'h0, 1'b0, 1'b0);
    cycle();
    chk("flush_no_ghost", bus.out_valid, 0);

    // Simultaneous accept and consume while holding one entry
    bus.out_ready = 1'b0;
    put(1'b1, 32'h5, 1'b0, 1'b0);
    cycle();
    bus.out_ready = 1'b1;
    put(1'b1, 32'h6, 1'b0, 1'b0);
    cycle();
    chk("swap_result", bus.out_result, 32'h6);
    chk("swap_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b0;
    put(1'b0, 32'h0, 1'b0, 1'b0);
    cycle();
    chk("swap_one_held", bus.out_result, 32'h6);

    // Asynchronous reset mid-cycle with two entries held
    put(1'b1, 32'h7, 1'b0, 1'b0);
    bus.in_reg_write = 1'b1;
    cycle();
    put(1'b0, 32'h0, 1'b0, 1'b0);
    chk("pre_reset_full", bus.in_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the FIFO model
    for (int i = 0; i < 400; i++) begin
      put(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
